// File: rtl/button_debouncer_pkg.sv
// debounce_pkg: shared definitions for the button debouncer.
//   - State encodings: bit[1] of the state is the debounced level, so db is
//     taken straight from a state flop with no decode logic.
//   - Default stability window and the counter-width helper.
package debounce_pkg;

    // 10 ms at 100 MHz.
    localparam int unsigned STABLE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        S_ZERO  = 2'b00,
        S_WAIT1 = 2'b01,
        S_ONE   = 2'b11,
        S_WAIT0 = 2'b10
    } db_state_e;

    // Counter must hold 0..n-1; keep at least one bit for n == 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button level in, debounced level out.
//   btn : raw asynchronous button level (driven by the master)
//   db  : debounced, registered level (driven by the debouncer)
interface button_debouncer_if;
    logic btn;
    logic db;

    modport master (output btn, input db);
    modport slave  (input btn, output db);
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk   : sampling clock
//   reset : synchronous, active-high; clears both flops to 0
//   d     : asynchronous input
//   q     : synchronized output (second flop)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync0_q;
    logic sync1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= d;
            sync1_q <= sync0_q;
        end
    end

    assign q = sync1_q;

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: debounces one mechanical button into a level-stable db.
//   clk   : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : slave side of button_debouncer_if (btn in, db out)
//
// db follows the synchronized button only after the new level has been seen
// on STABLE_CYCLES consecutive clocks after leaving the stable state; any
// return to the old level aborts and the next change starts again from 0.
//
//   state   | meaning
//   --------+------------------------------------------------
//   S_ZERO  | stable low, db=0
//   S_WAIT1 | input high, counting towards rise, db=0
//   S_ONE   | stable high, db=1
//   S_WAIT0 | input low, counting towards fall, db=1
module button_debouncer
    import debounce_pkg::*;
#(
    parameter  int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    localparam int unsigned CNT_W         = cnt_width(STABLE_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    button_debouncer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn),
        .q     (sync1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ZERO;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_ZERO: begin
                    if (sync1) begin
                        state_q <= S_WAIT1;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT1: begin
                    if (!sync1) begin
                        state_q <= S_ZERO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ONE: begin
                    if (!sync1) begin
                        state_q <= S_WAIT0;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT0: begin
                    if (sync1) begin
                        state_q <= S_ONE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ZERO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_ZERO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Encoding puts the debounced level in bit[1], so db is a plain flop output.
    assign bus.db = state_q[1];

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: two debouncers (STABLE_CYCLES=4 and =1) share one
// button. A reference model keeps the history of levels the FSM sees and
// flips its db whenever the last STABLE_CYCLES+1 seen levels all differ from
// the current db; each flip is queued with its edge number and a monitor
// pops the queue whenever a DUT's db changes.
module tb_button_debouncer;
    import debounce_pkg::*;

    localparam int N0 = 4;
    localparam int N1 = 1;

    typedef struct {
        int cyc;
        bit lvl;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic btn   = 1'b0;

    always #5 clk = ~clk;

    button_debouncer_if bus0 ();
    button_debouncer_if bus1 ();
    assign bus0.btn = btn;
    assign bus1.btn = btn;

    button_debouncer #(.STABLE_CYCLES(N0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    button_debouncer #(.STABLE_CYCLES(N1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   rst_cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   seen_arr [0:32767];
    bit   p0, p1;
    bit   mdb [2];
    bit   mon_en = 1'b0;
    bit   last_db [2];

    // ---------------- reference model ----------------
    task automatic push_exp(input int i, input int c, input bit l);
        exp_t e;
        e.cyc = c;
        e.lvl = l;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    always @(posedge clk) begin
        int  n;
        bit  all_eq;
        cyc++;
        if (reset) begin
            p0 = 1'b0;
            p1 = 1'b0;
            rst_cyc = cyc;
            for (int i = 0; i < 2; i++) begin
                if (mdb[i]) begin
                    mdb[i] = 1'b0;
                    push_exp(i, cyc, 1'b0);
                end
            end
        end else begin
            // Level the FSM acts on at this edge: button sampled two edges ago.
            seen_arr[cyc] = p1;
            p1 = p0;
            p0 = btn;
            for (int i = 0; i < 2; i++) begin
                n = (i == 0) ? N0 : N1;
                if (cyc - n > rst_cyc) begin
                    all_eq = 1'b1;
                    for (int j = cyc - n; j <= cyc; j++)
                        if (seen_arr[j] == mdb[i]) all_eq = 1'b0;
                    if (all_eq) begin
                        mdb[i] = ~mdb[i];
                        push_exp(i, cyc, mdb[i]);
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    function automatic bit q_empty(input int i);
        return (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    endfunction

    function automatic exp_t q_front(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic check_inst(input int i, input bit d);
        exp_t e;
        if (d != last_db[i]) begin
            last_db[i] = d;
            total++;
            if (q_empty(i)) begin
                bad++;
                $display("FAIL unexpected_db inst=%0d got lvl=%0b at cyc=%0d, expected no change", i, d, cyc);
            end else begin
                e = q_front(i);
                q_pop(i);
                if (e.cyc != cyc || e.lvl != d) begin
                    bad++;
                    $display("FAIL db_change inst=%0d got cyc=%0d lvl=%0b expected cyc=%0d lvl=%0b",
                             i, cyc, d, e.cyc, e.lvl);
                end
            end
        end
        if (!q_empty(i)) begin
            e = q_front(i);
            if (e.cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missed_db inst=%0d got lvl=%0b expected lvl=%0b at cyc=%0d", i, d, e.lvl, e.cyc);
                q_pop(i);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, bus0.db);
            check_inst(1, bus1.db);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0b expected=%0b", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input db_state_e exp_s);
        total++;
        if (dut.state_q !== exp_s) begin
            bad++;
            $display("FAIL %s got state=%0d expected state=%0d", name, dut.state_q, exp_s);
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        btn   = 1'b0;
        step(2);
        check_bit("reset_db0", bus0.db, 1'b0);
        check_bit("reset_db1", bus1.db, 1'b0);
        check_state("reset_state", S_ZERO);
        reset = 1'b0;
        last_db[0] = 1'b0;
        last_db[1] = 1'b0;
        mon_en = 1'b1;

        // Clean press, then clean release.
        btn = 1'b1; step(12);
        check_bit("press_db", bus0.db, 1'b1);
        btn = 1'b0; step(12);
        check_bit("release_db", bus0.db, 1'b0);

        // Bounce 1,0,1,0,1 then hold.
        btn = 1'b1; step(1);
        btn = 1'b0; step(1);
        btn = 1'b1; step(1);
        btn = 1'b0; step(1);
        btn = 1'b1; step(12);
        check_bit("bounce_db", bus0.db, 1'b1);
        btn = 1'b0; step(12);

        // High glitch of 3 clocks while low.
        btn = 1'b1; step(3);
        btn = 1'b0; step(8);
        check_bit("glitch_hi_db", bus0.db, 1'b0);
        check_state("glitch_hi_state", S_ZERO);

        // Low glitch of 3 clocks while high.
        btn = 1'b1; step(12);
        btn = 1'b0; step(3);
        btn = 1'b1; step(8);
        check_bit("glitch_lo_db", bus0.db, 1'b1);
        check_state("glitch_lo_state", S_ONE);
        btn = 1'b0; step(12);

        // Reset while counting in S_WAIT1 with cnt=2; button stays high.
        btn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (dut.state_q == S_WAIT1 && dut.cnt_q == 2) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait1_cnt2_timeout got found=0 expected found=1");
        end
        reset = 1'b1; step(1);
        reset = 1'b0;
        check_bit("midreset_db", bus0.db, 1'b0);
        check_state("midreset_state", S_ZERO);
        check_bit("midreset_cnt0", dut.cnt_q == 0, 1'b1);
        step(12);
        check_bit("midreset_rise", bus0.db, 1'b1);

        // Random segments with occasional resets.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 2));
                reset = 1'b0;
            end
            btn = 1'($urandom_range(0, 1));
            step($urandom_range(1, 10));
        end

        step(20);
        check_bit("final_db0", bus0.db, mdb[0]);
        check_bit("final_db1", bus1.db, mdb[1]);
        check_bit("final_q_empty", (q0.size() == 0) && (q1.size() == 0), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
